spi_master_arbiter: RTL and testbench

//  Round-robin arbiter plus transfer sequencer that shares one SPI slave between NREQ requesters.

---
 rtl/spi_master_arbiter.sv | 110 +++++++++++
 tb/tb_spi_master_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter sharing one SPI slave between NREQ requesters.
// Each grant runs one DW-bit MSB-first transfer, returns the received word and pulses done.
module spi_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int DW      = 8,
    parameter int GAP_CYC = 1
) (
    input  logic              i_sclk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_req_wr,
    input  logic [NREQ-1:0]   i_req_rd,
    input  logic [NREQ*DW-1:0] i_req_data,
    output logic [NREQ-1:0]   o_gnt,
    output logic [NREQ-1:0]   o_done,
    output logic [DW-1:0]     o_rd_data,
    output logic              o_cs,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic              o_wr_en,
    output logic              o_rd_en
);
    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(DW);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
    state_t r_state, w_next;
    logic [PW-1:0] r_ptr, w_win;
    logic [DW-1:0] r_shreg, w_data;
    logic [BW-1:0] r_bitcnt;
    logic [3:0] r_gapcnt;
    logic [NREQ-1:0] r_gnt, r_done;
    logic [DW-1:0] r_rd_data;
    logic r_cs, r_wr_en, r_rd_en, w_wr, w_rd, w_any, w_last, w_gap_end;
    assign w_any = |i_req;
    assign w_last = r_bitcnt == BW'(DW - 1);
    assign w_gap_end = r_gapcnt == 4'(GAP_CYC - 1);
    // Scan downward from ptr+NREQ-1 so the candidate closest to ptr is written last and wins.
    always_comb begin
        w_win = '0;
        w_data = '0;
        w_wr = 1'b0;
        w_rd = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(r_ptr) + k) % NREQ]) begin
                w_win = PW'((int'(r_ptr) + k) % NREQ);
                w_data = i_req_data[((int'(r_ptr) + k) % NREQ) * DW +: DW];
                w_wr = i_req_wr[(int'(r_ptr) + k) % NREQ];
                w_rd = i_req_rd[(int'(r_ptr) + k) % NREQ];
            end
        end
    end
    always_comb begin
        w_next = r_state == IDLE  ? (w_any ? SETUP : IDLE) :
                 r_state == SETUP ? SHIFT :
                 r_state == SHIFT ? (w_last ? GAP : SHIFT) :
                                    (w_gap_end ? IDLE : GAP);
    end
    always_ff @(posedge i_sclk) begin
        if (!i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge i_sclk) begin
        if (!i_reset) begin
            r_ptr <= '0;
            r_shreg <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_gnt <= '0;
            r_done <= '0;
            r_rd_data <= '0;
            r_cs <= 1'b1;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_gnt <= NREQ'(1) << w_win;
                    r_shreg <= w_data;
                    r_wr_en <= w_wr;
                    r_rd_en <= w_rd;
                    r_cs <= 1'b0;
                    r_ptr <= w_win == PW'(NREQ - 1) ? '0 : w_win + 1'b1;
                end
                SETUP: r_bitcnt <= '0;
                SHIFT: begin
                    r_shreg <= {r_shreg[DW-2:0], i_miso};
                    r_bitcnt <= r_bitcnt + 1'b1;
                    if (w_last) begin
                        r_cs <= 1'b1;
                        r_gnt <= '0;
                        r_wr_en <= 1'b0;
                        r_rd_en <= 1'b0;
                        r_done <= r_gnt;
                        r_rd_data <= {r_shreg[DW-2:0], i_miso};
                        r_gapcnt <= '0;
                    end
                end
                default: r_gapcnt <= r_gapcnt + 1'b1;
            endcase
        end
    end
    assign o_gnt = r_gnt;
    assign o_done = r_done;
    assign o_rd_data = r_rd_data;
    assign o_cs = r_cs;
    assign o_wr_en = r_wr_en;
    assign o_rd_en = r_rd_en;
    assign o_mosi = r_cs ? 1'bz : r_shreg[DW-1];
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: randomized transaction-level check of the SPI arbiter against a round-robin model.
module tb_spi_master_arbiter;
    localparam int NREQ = 2;
    localparam int DW = 8;
    localparam int GAP_CYC = 1;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic i_reset, i_miso;
    logic [NREQ-1:0] i_req, i_req_wr, i_req_rd, o_gnt, o_done;
    logic [NREQ*DW-1:0] i_req_data;
    logic [DW-1:0] o_rd_data;
    logic o_cs, o_mosi, o_wr_en, o_rd_en;
    int n_vec = 0;
    int n_err = 0;
    int ptr = 0;
    spi_master_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP_CYC)) dut (
        .i_sclk(clk), .i_reset(i_reset), .i_req(i_req), .i_req_wr(i_req_wr),
        .i_req_rd(i_req_rd), .i_req_data(i_req_data), .o_gnt(o_gnt), .o_done(o_done),
        .o_rd_data(o_rd_data), .o_cs(o_cs), .o_mosi(o_mosi), .i_miso(i_miso),
        .o_wr_en(o_wr_en), .o_rd_en(o_rd_en)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic scramble();
        i_req = NREQ'($urandom);
        i_req_wr = NREQ'($urandom);
        i_req_rd = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) i_req_data[i*DW +: DW] = DW'($urandom);
    endtask
    // noise: 0 = inputs held, 1 = inputs scrambled after grant, 2 = req dropped at E3
    task automatic txn(input logic [NREQ-1:0] m, input logic [NREQ*DW-1:0] dat,
                       input logic [NREQ-1:0] wr, input logic [NREQ-1:0] rd,
                       input logic [DW-1:0] miso_w, input int noise);
        int win;
        logic [DW-1:0] tx;
        logic [NREQ-1:0] oh;
        i_req = m;
        i_req_data = dat;
        i_req_wr = wr;
        i_req_rd = rd;
        if (m == '0) begin
            tick();
            check("idle_cs", 32'(o_cs), 32'(1'b1));
            check("idle_gnt", 32'(o_gnt), 32'(0));
            return;
        end
        win = -1;
        for (int k = 0; k < NREQ; k++)
            if (win < 0 && m[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
        ptr = (win + 1) % NREQ;
        tx = dat[win*DW +: DW];
        oh = '0;
        oh[win] = 1'b1;
        tick();
        check("grant_cs", 32'(o_cs), 32'(1'b0));
        check("grant_gnt", 32'(o_gnt), 32'(oh));
        check("grant_wr_en", 32'(o_wr_en), 32'(wr[win]));
        check("grant_rd_en", 32'(o_rd_en), 32'(rd[win]));
        for (int n = 1; n <= DW + 1; n++) begin
            if (noise == 1) scramble();
            if (noise == 2 && n == 3) i_req = '0;
            if (n >= 2) i_miso = miso_w[DW - n + 1];
            tick();
            if (n <= DW) begin
                check("mosi", 32'(o_mosi), 32'(tx[DW - n]));
                check("busy_cs", 32'(o_cs), 32'(1'b0));
                check("busy_gnt", 32'(o_gnt), 32'(oh));
                check("busy_done", 32'(o_done), 32'(0));
            end
        end
        check("done", 32'(o_done), 32'(oh));
        check("rd_data", 32'(o_rd_data), 32'(miso_w));
        check("end_cs", 32'(o_cs), 32'(1'b1));
        check("end_gnt", 32'(o_gnt), 32'(0));
        check("end_wr_en", 32'(o_wr_en), 32'(1'b0));
        check("end_rd_en", 32'(o_rd_en), 32'(1'b0));
        for (int g = 0; g < GAP_CYC; g++) begin
            if (noise == 1) scramble();
            tick();
            check("gap_cs", 32'(o_cs), 32'(1'b1));
            check("gap_done", 32'(o_done), 32'(0));
            check("gap_gnt", 32'(o_gnt), 32'(0));
        end
        check("hold_rd_data", 32'(o_rd_data), 32'(miso_w));
    endtask
    function automatic logic [NREQ*DW-1:0] rnd_data();
        logic [NREQ*DW-1:0] d;
        for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction
    initial begin
        i_reset = 1'b0;
        i_req = '0;
        i_req_wr = '0;
        i_req_rd = '0;
        i_req_data = '0;
        i_miso = 1'b0;
        tick();
        tick();
        check("rst_cs", 32'(o_cs), 32'(1'b1));
        check("rst_gnt", 32'(o_gnt), 32'(0));
        check("rst_done", 32'(o_done), 32'(0));
        check("rst_rd_data", 32'(o_rd_data), 32'(0));
        check("rst_wr_rd", 32'({o_wr_en, o_rd_en}), 32'(0));
        i_reset = 1'b1;
        txn(2'b01, {8'h00, 8'hA5}, 2'b01, 2'b00, 8'h3C, 0);
        for (int t = 0; t < 4; t++) txn(2'b11, rnd_data(), 2'b11, 2'b00, DW'($urandom), 0);
        txn(2'b10, rnd_data(), 2'b10, 2'b00, DW'($urandom), 0);
        txn(2'b01, rnd_data(), 2'b00, 2'b01, DW'($urandom), 2);
        txn(2'b01, rnd_data(), 2'b01, 2'b01, DW'($urandom), 0);
        txn(2'b01, rnd_data(), 2'b00, 2'b00, DW'($urandom), 0);
        i_req = 2'b10;
        i_req_data = rnd_data();
        tick();
        check("abort_start_cs", 32'(o_cs), 32'(1'b0));
        for (int t = 0; t < 4; t++) tick();
        i_reset = 1'b0;
        i_req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("abort_done", 32'(o_done), 32'(0));
        end
        check("abort_cs", 32'(o_cs), 32'(1'b1));
        check("abort_gnt", 32'(o_gnt), 32'(0));
        check("abort_rd_data", 32'(o_rd_data), 32'(0));
        check("abort_wr_rd", 32'({o_wr_en, o_rd_en}), 32'(0));
        i_reset = 1'b1;
        ptr = 0;
        txn(2'b11, rnd_data(), 2'b00, 2'b00, DW'($urandom), 0);
        for (int t = 0; t < 40; t++)
            txn(NREQ'($urandom), rnd_data(), NREQ'($urandom), NREQ'($urandom), DW'($urandom), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
